// File: rtl/mem_bus_arbiter.sv
// Shares a single-port RAM between the CPU core (default owner) and one DMA client.
// DMA bursts freeze the core; the CPU address is replayed before the core is released.
//
// state     | meaning
// S_CPU     | core owns the bus, counts enabled cycles toward the next DMA window
// S_DMA     | core frozen, DMA requests granted until burst limit or request drop
// S_RESTORE | core still frozen, RAM re-reads cpu_addr so the core sees its own data
module mem_bus_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int CPU_MIN   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              core_en,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int CW = $clog2(CPU_MIN + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [CW-1:0] CPU_SAT    = CW'(CPU_MIN);

  typedef enum logic [1:0] {S_CPU, S_DMA, S_RESTORE} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [CW-1:0]   cpu_cnt_q, cpu_cnt_d;
  logic            dma_rvalid_q, dma_rvalid_d;

  assign cpu_rdata  = ram_rdata;
  assign dma_rdata  = ram_rdata;
  assign dma_rvalid = dma_rvalid_q;

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    cpu_cnt_d    = cpu_cnt_q;
    dma_rvalid_d = (state_q == S_DMA) && dma_req && !dma_we;
    ram_addr     = cpu_addr;
    ram_wdata    = cpu_wdata;
    ram_we       = 1'b0;
    core_en      = 1'b1;
    dma_gnt      = 1'b0;

    unique case (state_q)
      S_CPU: begin
        ram_we = cpu_we;
        if (cpu_cnt_q != CPU_SAT) cpu_cnt_d = cpu_cnt_q + 1'b1;
        // a core write in flight always completes before the DMA takes over
        if (dma_req && !cpu_we && (cpu_cnt_q >= CPU_SAT)) begin
          state_d     = S_DMA;
          burst_cnt_d = '0;
        end
      end
      S_DMA: begin
        core_en   = 1'b0;
        ram_addr  = dma_addr;
        ram_wdata = dma_wdata;
        dma_gnt   = dma_req;
        ram_we    = dma_req && dma_we;
        if (dma_req) burst_cnt_d = burst_cnt_q + 1'b1;
        if (!dma_req || (burst_cnt_q == BURST_LAST)) state_d = S_RESTORE;
      end
      S_RESTORE: begin
        core_en   = 1'b0;
        state_d   = S_CPU;
        cpu_cnt_d = '0;
      end
      default: state_d = S_CPU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CPU;
      burst_cnt_q  <= '0;
      cpu_cnt_q    <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      cpu_cnt_q    <= cpu_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: bench-side RAM, cycle-level reference model of the
// ownership rules, directed scenarios plus a randomized run.
module tb_mem_bus_arbiter;
  localparam int ADDR_W = 16, DATA_W = 8, MAX_BURST = 4, CPU_MIN = 2;

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] cpu_addr, dma_addr, ram_addr;
  logic cpu_we, dma_req, dma_we, core_en, dma_gnt, dma_rvalid, ram_we;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata, dma_wdata, dma_rdata, ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .CPU_MIN(CPU_MIN)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .core_en(core_en),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Bench RAM with a backdoor load port, registered read.
  logic [DATA_W-1:0] mem [0:65535];
  logic pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int n_checks = 0, n_pass = 0;

  // Reference model: who owns the bus, counted in enabled cycles and grants.
  logic [DATA_W-1:0] shadow [0:65535];
  bit m_frozen = 0, m_closing = 0, m_pend_rv = 0, m_cpu_pend = 0;
  int m_since = 0, m_grants = 0;
  logic [DATA_W-1:0] m_pend_rd = '0, m_cpu_val = '0;

  logic e_core_en, e_gnt, e_we, e_rvalid, e_cpu_chk;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata, e_rdata, e_cpu_rdata;

  task automatic eval();
    @(negedge clk);
    e_rvalid = m_pend_rv; e_rdata = m_pend_rd;
    e_cpu_chk = m_cpu_pend; e_cpu_rdata = m_cpu_val;
    m_pend_rv = 0; m_cpu_pend = 0;
    e_gnt = 0; e_wdata = cpu_wdata;
    if (!m_frozen) begin
      e_core_en = 1; e_addr = cpu_addr; e_we = cpu_we;
      if (cpu_we) shadow[cpu_addr] = cpu_wdata;
      if (dma_req && !cpu_we && m_since >= CPU_MIN) begin m_frozen = 1; m_grants = 0; end
      else m_since++;
    end else if (!m_closing) begin
      e_core_en = 0; e_addr = dma_addr; e_wdata = dma_wdata;
      e_gnt = dma_req; e_we = dma_req && dma_we;
      if (dma_req) begin
        m_grants++;
        if (dma_we) shadow[dma_addr] = dma_wdata;
        else begin m_pend_rv = 1; m_pend_rd = shadow[dma_addr]; end
      end
      if (!dma_req || m_grants == MAX_BURST) m_closing = 1;
    end else begin
      e_core_en = 0; e_addr = cpu_addr; e_we = 0;
      m_frozen = 0; m_closing = 0; m_since = 0;
      m_cpu_pend = 1; m_cpu_val = shadow[cpu_addr];
    end
    if (rst) begin
      m_frozen = 0; m_closing = 0; m_since = 0; m_pend_rv = 0; m_cpu_pend = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1; shadow[a] = d;
    eval(); tick();
    pre_we = 1'b0;
  endtask

  task automatic drain(input int n);
    dma_req = 1'b0; cpu_we = 1'b0;
    for (int i = 0; i < n; i++) begin eval(); tick(); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    eval(); tick(); eval(); tick();
    rst = 1'b0;
    eval();
    n_checks++; if (core_en !== 1'b1) $display("FAIL rst_core_en got=%0h want=1", core_en); else n_pass++;
    n_checks++; if (dma_gnt !== 1'b0) $display("FAIL rst_dma_gnt got=%0h want=0", dma_gnt); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL rst_ram_we got=%0h want=0", ram_we); else n_pass++;
    n_checks++; if (dma_rvalid !== 1'b0) $display("FAIL rst_rvalid got=%0h want=0", dma_rvalid); else n_pass++;
    tick();
  endtask

  task automatic test_no_dma();
    dma_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cpu_addr = ADDR_W'($urandom_range(0, 15));
      cpu_we = ($urandom_range(0, 3) == 0);
      cpu_wdata = DATA_W'($urandom);
      eval();
      n_checks++; if (core_en !== 1'b1) $display("FAIL nodma_core_en cyc=%0d got=%0h want=1", i, core_en); else n_pass++;
      n_checks++; if (ram_addr !== cpu_addr) $display("FAIL nodma_ram_addr cyc=%0d got=%0h want=%0h", i, ram_addr, cpu_addr); else n_pass++;
      n_checks++; if (ram_we !== cpu_we) $display("FAIL nodma_ram_we cyc=%0d got=%0h want=%0h", i, ram_we, cpu_we); else n_pass++;
      tick();
    end
    cpu_we = 1'b0;
  endtask

  // Six reads held back to back: a full window, restore, CPU gap, then a partial window.
  task automatic test_burst();
    int granted, w2;
    logic xg, xe;
    granted = 0;
    w2 = MAX_BURST + CPU_MIN + 3;
    cpu_we = 1'b0; dma_we = 1'b0;
    for (int c = 0; c < w2 + 2; c++) begin
      dma_req = (granted < 6);
      dma_addr = ADDR_W'($urandom_range(0, 15));
      eval();
      xg = (c >= 1 && c <= MAX_BURST) || (c >= w2 && c < w2 + 2);
      xe = (c == 0) || (c > MAX_BURST + 1 && c < w2);
      n_checks++; if (dma_gnt !== xg) $display("FAIL burst_gnt cyc=%0d got=%0h want=%0h", c, dma_gnt, xg); else n_pass++;
      n_checks++; if (core_en !== xe) $display("FAIL burst_core_en cyc=%0d got=%0h want=%0h", c, core_en, xe); else n_pass++;
      n_checks++; if (dma_rvalid !== e_rvalid) $display("FAIL burst_rvalid cyc=%0d got=%0h want=%0h", c, dma_rvalid, e_rvalid); else n_pass++;
      if (e_gnt) granted++;
      tick();
    end
    n_checks++; if (granted != 6) $display("FAIL burst_total got=%0d want=6", granted); else n_pass++;
    dma_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      eval();
      xe = (c == 2);
      n_checks++; if (core_en !== xe) $display("FAIL burst_tail_core_en cyc=%0d got=%0h want=%0h", c, core_en, xe); else n_pass++;
      tick();
    end
  endtask

  task automatic test_cpu_write_block();
    drain(3);
    cpu_addr = 16'h0005; cpu_we = 1'b1; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0006;
    for (int c = 0; c < 3; c++) begin
      cpu_wdata = DATA_W'($urandom);
      eval();
      n_checks++; if (dma_gnt !== 1'b0) $display("FAIL wblk_gnt cyc=%0d got=%0h want=0", c, dma_gnt); else n_pass++;
      n_checks++; if (ram_we !== 1'b1) $display("FAIL wblk_ram_we cyc=%0d got=%0h want=1", c, ram_we); else n_pass++;
      tick();
    end
    cpu_we = 1'b0;
    eval();
    n_checks++; if (core_en !== 1'b1 || dma_gnt !== 1'b0) $display("FAIL wblk_release got=%0h%0h want=10", core_en, dma_gnt); else n_pass++;
    tick(); eval();
    n_checks++; if (dma_gnt !== 1'b1) $display("FAIL wblk_first_gnt got=%0h want=1", dma_gnt); else n_pass++;
    tick();
    drain(5);
  endtask

  task automatic test_dma_rw();
    cpu_we = 1'b0; dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0F00; dma_wdata = 8'hA5;
    eval(); tick(); eval();
    n_checks++; if (dma_gnt !== 1'b1 || ram_we !== 1'b1) $display("FAIL rw_wr_gnt got=%0h%0h want=11", dma_gnt, ram_we); else n_pass++;
    n_checks++; if (ram_addr !== 16'h0F00 || ram_wdata !== 8'hA5) $display("FAIL rw_wr_bus got=%0h/%0h want=f00/a5", ram_addr, ram_wdata); else n_pass++;
    tick();
    dma_we = 1'b0;
    eval();
    n_checks++; if (dma_gnt !== 1'b1 || ram_we !== 1'b0) $display("FAIL rw_rd_gnt got=%0h%0h want=10", dma_gnt, ram_we); else n_pass++;
    tick();
    dma_req = 1'b0;
    eval();
    n_checks++; if (dma_rvalid !== 1'b1) $display("FAIL rw_rvalid got=%0h want=1", dma_rvalid); else n_pass++;
    n_checks++; if (dma_rdata !== 8'hA5) $display("FAIL rw_rdata got=%0h want=a5", dma_rdata); else n_pass++;
    tick();
    drain(5);
  endtask

  task automatic test_restore_data();
    bit found;
    poke(16'h0123, 8'h3C);
    poke(16'h0200, 8'h11);
    drain(3);
    cpu_addr = 16'h0123; cpu_we = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200;
    eval(); tick(); eval();
    n_checks++; if (dma_gnt !== 1'b1) $display("FAIL rest_gnt got=%0h want=1", dma_gnt); else n_pass++;
    tick();
    dma_req = 1'b0;
    eval();
    n_checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 8'h11) $display("FAIL rest_dma_rdata got=%0h/%0h want=1/11", dma_rvalid, dma_rdata); else n_pass++;
    tick();
    found = 0;
    for (int c = 0; c < 6 && !found; c++) begin
      eval();
      if (core_en === 1'b1) begin
        found = 1;
        n_checks++; if (cpu_rdata !== 8'h3C) $display("FAIL rest_cpu_rdata got=%0h want=3c", cpu_rdata); else n_pass++;
      end
      tick();
    end
    n_checks++; if (!found) $display("FAIL rest_core_release got=timeout want=core_en"); else n_pass++;
    drain(3);
  endtask

  task automatic test_reset_mid_burst();
    cpu_addr = 16'h0007; cpu_we = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0003;
    eval(); tick(); eval(); tick();
    rst = 1'b1;
    eval();
    n_checks++; if (dma_gnt !== 1'b1) $display("FAIL rmb_second_gnt got=%0h want=1", dma_gnt); else n_pass++;
    tick();
    rst = 1'b0; dma_req = 1'b0;
    eval();
    n_checks++; if (core_en !== 1'b1) $display("FAIL rmb_core_en got=%0h want=1", core_en); else n_pass++;
    n_checks++; if (dma_gnt !== 1'b0) $display("FAIL rmb_gnt got=%0h want=0", dma_gnt); else n_pass++;
    n_checks++; if (dma_rvalid !== 1'b0) $display("FAIL rmb_rvalid got=%0h want=0", dma_rvalid); else n_pass++;
    n_checks++; if (ram_addr !== cpu_addr) $display("FAIL rmb_ram_addr got=%0h want=%0h", ram_addr, cpu_addr); else n_pass++;
    tick();
  endtask

  // Random traffic; the core only moves on after a cycle in which it was enabled.
  task automatic test_random();
    logic last_en;
    last_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (last_en) begin
        cpu_addr = ADDR_W'($urandom_range(0, 15));
        cpu_we = ($urandom_range(0, 3) == 0);
        cpu_wdata = DATA_W'($urandom);
      end
      dma_req = ($urandom_range(0, 3) != 0);
      dma_we = 1'($urandom_range(0, 1));
      dma_addr = ADDR_W'($urandom_range(0, 15));
      dma_wdata = DATA_W'($urandom);
      eval();
      n_checks++; if (core_en !== e_core_en) $display("FAIL rnd_core_en cyc=%0d got=%0h want=%0h", i, core_en, e_core_en); else n_pass++;
      n_checks++; if (dma_gnt !== e_gnt) $display("FAIL rnd_gnt cyc=%0d got=%0h want=%0h", i, dma_gnt, e_gnt); else n_pass++;
      n_checks++; if (ram_addr !== e_addr) $display("FAIL rnd_ram_addr cyc=%0d got=%0h want=%0h", i, ram_addr, e_addr); else n_pass++;
      n_checks++; if (ram_we !== e_we) $display("FAIL rnd_ram_we cyc=%0d got=%0h want=%0h", i, ram_we, e_we); else n_pass++;
      if (e_we) begin
        n_checks++; if (ram_wdata !== e_wdata) $display("FAIL rnd_ram_wdata cyc=%0d got=%0h want=%0h", i, ram_wdata, e_wdata); else n_pass++;
      end
      n_checks++; if (dma_rvalid !== e_rvalid) $display("FAIL rnd_rvalid cyc=%0d got=%0h want=%0h", i, dma_rvalid, e_rvalid); else n_pass++;
      if (e_rvalid) begin
        n_checks++; if (dma_rdata !== e_rdata) $display("FAIL rnd_dma_rdata cyc=%0d got=%0h want=%0h", i, dma_rdata, e_rdata); else n_pass++;
      end
      if (e_cpu_chk) begin
        n_checks++; if (cpu_rdata !== e_cpu_rdata) $display("FAIL rnd_cpu_rdata cyc=%0d got=%0h want=%0h", i, cpu_rdata, e_cpu_rdata); else n_pass++;
      end
      last_en = e_core_en;
      tick();
    end
    drain(4);
  endtask

  initial begin
    rst = 1'b1; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    test_reset();
    for (int a = 0; a < 16; a++) poke(ADDR_W'(a), DATA_W'($urandom));
    test_no_dma();
    test_burst();
    test_cpu_write_block();
    test_dma_rw();
    test_restore_data();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
